rect_draw_engine: RTL
=====================

Name: rect_draw_engine

Overview:
- Parametrised pixel-generation engine for the VGA path. It replaces the hand-coded per-shape counter blocks (gallows, dashes, body parts, clear-screen) with one command-driven rasteriser.
- Control logic pushes rectangle commands into a small FIFO.
- The engine emits one {x, y, colour} pixel per accepted handshake toward the VGA adapter.
- Supported modes: filled rectangle, outline rectangle and full-screen clear, with screen clipping and output backpressure.

Parameters:
- X_W, 8, x coordinate / width bit count
- Y_W, 7, y coordinate / height bit count
- COLOR_W, 3, colour bit count
- FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command
- cmd_x  in  X_W  top-left x
- cmd_y  in  Y_W  top-left y
- cmd_w  in  X_W  width in pixels
- cmd_h  in  Y_W  height in pixels
- cmd_color  in  COLOR_W  colour
- cmd_mode  in  2  00 fill, 01 outline, 10 clear, 11 no-op
- pix_x  out  X_W  pixel x
- pix_y  out  Y_W  pixel y
- pix_color  out  COLOR_W  pixel colour
- pix_valid  out  1  pixel present
- pix_ready  in  1  VGA side accepts pixel
- cmd_done  out  1  one-cycle pulse when a command finishes
- busy  out  1  (state != IDLE) or FIFO non-empty
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset: resetn is asynchronous and active-high. While it is asserted, all outputs read 0, except cmd_ready, which reads 1.
  - FIFO contents are discarded and the state machine goes to IDLE.
  - A reset during RUN drops the command in progress: pix_valid falls immediately and no cmd_done is issued.
- FIFO:
  - Push occurs on cmd_valid && cmd_ready.
  - cmd_ready = (fifo_count < FIFO_DEPTH), computed from the count only; there is no same-cycle pass-through when full.
  - A simultaneous push and pop leaves the count unchanged.
- State machine, states IDLE, LOAD, RUN, DONE:
  - IDLE: if FIFO non-empty, pop and go to LOAD.
  - LOAD: latch x0, y0, colour and mode, and compute the end coordinates:
    - xe = x0+w-1 in X_W+1 bits; ye = y0+h-1 in Y_W+1 bits (no wrap).
    - Clear mode forces x0=0, y0=0, xe=SCREEN_W-1, ye=SCREEN_H-1.
    - If w==0, h==0 or mode==11, go to DONE; otherwise set cx=x0, cy=y0 and go to RUN.
  - RUN: raster order, x inner and y outer.
    - The current pixel is on-screen when cx<SCREEN_W and cy<SCREEN_H.
    - On-screen pixel: pix_valid=1. pix_x, pix_y and pix_color stay stable until pix_valid && pix_ready; the engine advances on that handshake.
    - Clipped pixel: pix_valid=0; the engine advances the next cycle without waiting.
    - Advance: if cx==xe, then cx=x0 and cy=cy+1; otherwise step x as follows.
      - Outline mode: on rows with y0<cy<ye, the step from cx==x0 goes directly to xe. When w==1, the column is emitted once per row.
      - Other modes: cx=cx+1.
    - Advancing past (xe, ye) goes to DONE.
  - DONE: assert cmd_done for 1 cycle. Next state is LOAD if the FIFO is non-empty (pop in this cycle), otherwise IDLE.
- Latency:
  - A push into an empty FIFO with the engine in IDLE gives first pix_valid 3 cycles after the push edge: pop, LOAD, RUN.
  - With pix_ready held at 1, throughput is 1 pixel per cycle.
  - Command-to-command gap is 2 cycles (DONE, LOAD).
- Outline pixel count: 2w+2(h-2) for w,h>=2; w*h otherwise.
- pix_valid is never asserted outside RUN.

Test Plan:
- Fill at (10,5), w=2, h=2, colour 3, pix_ready=1 -> pixels (10,5),(11,5),(10,6),(11,6), all with colour 3, on consecutive cycles; cmd_done pulses 1 cycle after the 4th handshake.
- Outline at (0,0), w=4, h=3 -> 10 pixels in order:
  - (0,0),(1,0),(2,0),(3,0)
  - (0,1),(3,1)
  - (0,2),(1,2),(2,2),(3,2)
- Clipping: fill at (158,118), w=4, h=4 -> only (158,118),(159,118),(158,119),(159,119) emitted; cmd_done still pulses; w=0 command -> cmd_done with no pixels.
- Backpressure: drop pix_ready for 3 cycles mid-rectangle -> pix_valid stays high with pix_x/pix_y unchanged; no pixels are lost or duplicated.
- FIFO full: 6 back-to-back commands with pix_ready=0 -> 5 accepted (1 in engine, 4 in FIFO); cmd_ready low on the 6th; fifo_count=4; the 6th is accepted 1 cycle after the engine pops the next entry.
- Clear mode colour 0 -> 19200 pixels, last (159,119), then cmd_done. Asserting resetn mid-clear -> pix_valid=0 and busy=0 immediately; no cmd_done.

Source files
------------

// File: rtl/rect_draw_if.sv
// Command and pixel channels of the rectangle rasteriser.
// The slave side is the engine; the master side is the control logic and the VGA adapter.
interface rect_draw_if #(
  parameter int unsigned X_W        = 8,
  parameter int unsigned Y_W        = 7,
  parameter int unsigned COLOR_W    = 3,
  parameter int unsigned FIFO_DEPTH = 4
) ();
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [X_W-1:0]     cmd_x;
  logic [Y_W-1:0]     cmd_y;
  logic [X_W-1:0]     cmd_w;
  logic [Y_W-1:0]     cmd_h;
  logic [COLOR_W-1:0] cmd_color;
  logic [1:0]         cmd_mode;
  logic [X_W-1:0]     pix_x;
  logic [Y_W-1:0]     pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_valid;
  logic               pix_ready;
  logic               cmd_done;
  logic               busy;
  logic [CNT_W-1:0]   fifo_count;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_mode, pix_ready,
    output cmd_ready, pix_x, pix_y, pix_color, pix_valid, cmd_done, busy, fifo_count
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_mode, pix_ready,
    input  cmd_ready, pix_x, pix_y, pix_color, pix_valid, cmd_done, busy, fifo_count
  );
endinterface

// File: rtl/rect_draw_engine.sv
// Command-driven rectangle rasteriser: FIFO of fill/outline/clear commands in, one
// clipped {x, y, colour} pixel per handshake out.
module rect_draw_engine #(
  parameter int unsigned X_W        = 8,
  parameter int unsigned Y_W        = 7,
  parameter int unsigned COLOR_W    = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SCREEN_W   = 160,
  parameter int unsigned SCREEN_H   = 120
) (
  input  logic       clk,
  input  logic       resetn,
  rect_draw_if.slave bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);
  localparam logic [X_W:0]  ScrW   = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]  ScrH   = (Y_W + 1)'(SCREEN_H);
  localparam logic [X_W:0]  XOne   = (X_W + 1)'(1);
  localparam logic [Y_W:0]  YOne   = (Y_W + 1)'(1);

  typedef struct packed {
    logic [1:0]         mode;
    logic [COLOR_W-1:0] color;
    logic [Y_W-1:0]     h;
    logic [X_W-1:0]     w;
    logic [Y_W-1:0]     y;
    logic [X_W-1:0]     x;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e             state_q, state_d;
  cmd_t               mem_q [FIFO_DEPTH];
  cmd_t               cmd_q;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic               push, pop;
  logic [X_W:0]       x0_q, xe_q, cx_q, nx;
  logic [Y_W:0]       y0_q, ye_q, cy_q;
  logic [COLOR_W-1:0] color_q;
  logic [1:0]         mode_q;
  logic [X_W:0]       ld_x0, ld_xe;
  logic [Y_W:0]       ld_y0, ld_ye;
  logic               ld_clear, ld_empty;
  logic               on_screen, adv, last_col, last_pix, interior_row;

  // Ready depends on the count only, so a full FIFO never passes a command through.
  assign bus.cmd_ready = count_q < DepthC;
  assign push          = bus.cmd_valid && bus.cmd_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{mode: bus.cmd_mode, color: bus.cmd_color, h: bus.cmd_h,
                           w: bus.cmd_w, y: bus.cmd_y, x: bus.cmd_x};
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cmd_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        cmd_q    <= mem_q[rd_ptr_q];
      end
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // End coordinates carry one extra bit so rectangles running off-screen do not wrap.
  always_comb begin
    ld_clear = cmd_q.mode == 2'b10;
    ld_empty = (cmd_q.w == '0) || (cmd_q.h == '0) || (cmd_q.mode == 2'b11);
    ld_x0    = ld_clear ? '0 : {1'b0, cmd_q.x};
    ld_y0    = ld_clear ? '0 : {1'b0, cmd_q.y};
    ld_xe    = ld_clear ? ScrW - XOne : {1'b0, cmd_q.x} + {1'b0, cmd_q.w} - XOne;
    ld_ye    = ld_clear ? ScrH - YOne : {1'b0, cmd_q.y} + {1'b0, cmd_q.h} - YOne;
  end

  always_comb begin
    on_screen    = (cx_q < ScrW) && (cy_q < ScrH);
    adv          = (state_q == StRun) && (!on_screen || bus.pix_ready);
    last_col     = cx_q == xe_q;
    last_pix     = last_col && (cy_q == ye_q);
    interior_row = (cy_q > y0_q) && (cy_q < ye_q);
    if (last_col) begin
      nx = x0_q;
    end else if ((mode_q == 2'b01) && interior_row && (cx_q == x0_q)) begin
      nx = xe_q;
    end else begin
      nx = cx_q + XOne;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      x0_q    <= '0;
      y0_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      color_q <= '0;
      mode_q  <= '0;
    end else if (state_q == StLoad) begin
      x0_q    <= ld_x0;
      y0_q    <= ld_y0;
      xe_q    <= ld_xe;
      ye_q    <= ld_ye;
      cx_q    <= ld_x0;
      cy_q    <= ld_y0;
      color_q <= cmd_q.color;
      mode_q  <= cmd_q.mode;
    end else if (adv) begin
      cx_q <= nx;
      if (last_col) cy_q <= cy_q + YOne;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: state_d = ld_empty ? StDone : StRun;
      StRun: begin
        if (adv && last_pix) state_d = StDone;
      end
      StDone: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StLoad;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.pix_valid  = (state_q == StRun) && on_screen;
  assign bus.pix_x      = cx_q[X_W-1:0];
  assign bus.pix_y      = cy_q[Y_W-1:0];
  assign bus.pix_color  = color_q;
  assign bus.cmd_done   = state_q == StDone;
  assign bus.busy       = (state_q != StIdle) || (count_q != '0);
  assign bus.fifo_count = count_q;
endmodule
